// File: rtl/ipsxe_floating_point_stim_rom_driver.sv
// Purpose : turns (valid, addr) strobes from the ROM address counter into
//           single-precision operand pairs on an AXI-stream master port.
// Latency : 2 cycles from in_valid to m_axis_tvalid when the vector FIFO is empty.
// Backpr. : tready stalls the FIFO head. Upstream has no ready, so a vector that
//           arrives at a full FIFO with no pop that cycle is dropped and counted.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   in_valid, in_addr     address strobe and ROM address
//   m_axis_tready         core accepts the current beat
//   m_axis_tvalid         a beat is available
//   m_axis_tdata_a/_b     operand A / operand B (IEEE-754 single)
//   m_axis_tlast          beat carries vector LAST_ADDR
//   m_axis_tuser          ROM address of the head beat (only with FLT_STIM_TUSER_EN)
//   done                  sticky: a tlast beat was handshaken
//   overflow              sticky: at least one vector was dropped
//   drop_cnt              dropped vectors, saturating at 15
//
// Optional feature macro: FLT_STIM_TUSER_EN (adds m_axis_tuser and per-entry address storage).

module ipsxe_floating_point_stim_rom_driver #(
   parameter int ADDR_W     = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int LAST_ADDR  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic              m_axis_tready,
   output logic              m_axis_tvalid,
   output logic [31:0]       m_axis_tdata_a,
   output logic [31:0]       m_axis_tdata_b,
   output logic              m_axis_tlast,
`ifdef FLT_STIM_TUSER_EN
   output logic [ADDR_W-1:0] m_axis_tuser,
`endif
   output logic              done,
   output logic              overflow,
   output logic [3:0]        drop_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // ------------------------------------------------------------------
   // ROM lookup (combinational on the incoming address)
   // ------------------------------------------------------------------
   logic [31:0] w_rom_a;
   logic [31:0] w_rom_b;

   always_comb begin
      w_rom_a = 32'h0000_0000;
      w_rom_b = 32'h0000_0000;
      case (in_addr)
         ADDR_W'(0): begin w_rom_a = 32'h3F80_0000; w_rom_b = 32'h4000_0000; end
         ADDR_W'(1): begin w_rom_a = 32'h4040_0000; w_rom_b = 32'h4080_0000; end
         ADDR_W'(2): begin w_rom_a = 32'hBF80_0000; w_rom_b = 32'h3F00_0000; end
         ADDR_W'(3): begin w_rom_a = 32'h7F80_0000; w_rom_b = 32'h3F80_0000; end
         ADDR_W'(4): begin w_rom_a = 32'h0000_0000; w_rom_b = 32'h8000_0000; end
         default:    begin w_rom_a = 32'h0000_0000; w_rom_b = 32'h0000_0000; end
      endcase
   end

   // ------------------------------------------------------------------
   // Stage 1: registered ROM read
   // ------------------------------------------------------------------
   logic              r_rd_vld;
   logic [31:0]       r_rd_a;
   logic [31:0]       r_rd_b;
   logic              r_rd_last;
`ifdef FLT_STIM_TUSER_EN
   logic [ADDR_W-1:0] r_rd_addr;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_vld  <= 1'b0;
         r_rd_a    <= 32'h0;
         r_rd_b    <= 32'h0;
         r_rd_last <= 1'b0;
`ifdef FLT_STIM_TUSER_EN
         r_rd_addr <= '0;
`endif
      end else begin
         r_rd_vld <= in_valid;
         if (in_valid) begin
            r_rd_a    <= w_rom_a;
            r_rd_b    <= w_rom_b;
            r_rd_last <= (in_addr == ADDR_W'(LAST_ADDR));
`ifdef FLT_STIM_TUSER_EN
            r_rd_addr <= in_addr;
`endif
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: vector FIFO
   // ------------------------------------------------------------------
   logic [31:0]       r_mem_a    [FIFO_DEPTH];
   logic [31:0]       r_mem_b    [FIFO_DEPTH];
   logic              r_mem_last [FIFO_DEPTH];
`ifdef FLT_STIM_TUSER_EN
   logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
`endif
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_done;
   logic              r_overflow;
   logic [3:0]        r_drop_cnt;

   logic              w_full;
   logic              w_pop;
   logic              w_wr;
   logic              w_drop;

   assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_pop  = m_axis_tvalid & m_axis_tready;
   // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
   assign w_wr   = r_rd_vld & (~w_full | w_pop);
   assign w_drop = r_rd_vld & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem_a[i]    <= 32'h0;
            r_mem_b[i]    <= 32'h0;
            r_mem_last[i] <= 1'b0;
`ifdef FLT_STIM_TUSER_EN
            r_mem_addr[i] <= '0;
`endif
         end
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
         r_drop_cnt <= 4'd0;
      end else begin
         if (w_wr) begin
            r_mem_a[r_wptr]    <= r_rd_a;
            r_mem_b[r_wptr]    <= r_rd_b;
            r_mem_last[r_wptr] <= r_rd_last;
`ifdef FLT_STIM_TUSER_EN
            r_mem_addr[r_wptr] <= r_rd_addr;
`endif
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 4'd15) begin
               r_drop_cnt <= r_drop_cnt + 4'd1;
            end
         end
         if (w_pop & m_axis_tlast) begin
            r_done <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs: head of FIFO, selected by a registered read pointer, so the
   // beat data has no combinational dependence on tready.
   // ------------------------------------------------------------------
   assign m_axis_tvalid  = (r_count != '0);
   assign m_axis_tdata_a = r_mem_a[r_rptr];
   assign m_axis_tdata_b = r_mem_b[r_rptr];
   assign m_axis_tlast   = r_mem_last[r_rptr];
`ifdef FLT_STIM_TUSER_EN
   assign m_axis_tuser   = r_mem_addr[r_rptr];
`endif
   assign done           = r_done;
   assign overflow       = r_overflow;
   assign drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_ipsxe_floating_point_stim_rom_driver.sv
// Directed bench for ipsxe_floating_point_stim_rom_driver: linear stimulus with
// hand-computed operand values, immediate assertions at each comparison point.
// Build with FLT_STIM_TUSER_EN defined to also cover the tuser sideband.

module tb_ipsxe_floating_point_stim_rom_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [3:0]  in_addr;
   logic        m_axis_tready;
   logic        m_axis_tvalid;
   logic [31:0] m_axis_tdata_a;
   logic [31:0] m_axis_tdata_b;
   logic        m_axis_tlast;
`ifdef FLT_STIM_TUSER_EN
   logic [3:0]  m_axis_tuser;
`endif
   logic        done;
   logic        overflow;
   logic [3:0]  drop_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ipsxe_floating_point_stim_rom_driver #(
      .ADDR_W     (4),
      .FIFO_DEPTH (4),
      .LAST_ADDR  (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_addr        (in_addr),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tdata_a (m_axis_tdata_a),
      .m_axis_tdata_b (m_axis_tdata_b),
      .m_axis_tlast   (m_axis_tlast),
`ifdef FLT_STIM_TUSER_EN
      .m_axis_tuser   (m_axis_tuser),
`endif
      .done           (done),
      .overflow       (overflow),
      .drop_cnt       (drop_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [3:0] a);
      in_valid = 1'b1;
      in_addr  = a;
      tick();
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // Addresses 1..4 with tready=1 from an empty FIFO and done=0.
   task automatic run_s1(input string p);
      m_axis_tready = 1'b1;
      strobe(4'd1);
      chk({p, "_tvalid_c1"}, 32'(m_axis_tvalid), 32'd0);
      strobe(4'd2);
      chk({p, "_tvalid_c2"}, 32'(m_axis_tvalid), 32'd1);
      chk({p, "_a_b1"}, m_axis_tdata_a, 32'h4040_0000);
      chk({p, "_b_b1"}, m_axis_tdata_b, 32'h4080_0000);
      chk({p, "_last_b1"}, 32'(m_axis_tlast), 32'd0);
`ifdef FLT_STIM_TUSER_EN
      chk({p, "_user_b1"}, 32'(m_axis_tuser), 32'd1);
`endif
      strobe(4'd3);
      chk({p, "_a_b2"}, m_axis_tdata_a, 32'hBF80_0000);
      chk({p, "_b_b2"}, m_axis_tdata_b, 32'h3F00_0000);
      chk({p, "_last_b2"}, 32'(m_axis_tlast), 32'd0);
`ifdef FLT_STIM_TUSER_EN
      chk({p, "_user_b2"}, 32'(m_axis_tuser), 32'd2);
`endif
      strobe(4'd4);
      in_valid = 1'b0;
      chk({p, "_a_b3"}, m_axis_tdata_a, 32'h7F80_0000);
      chk({p, "_last_b3"}, 32'(m_axis_tlast), 32'd0);
`ifdef FLT_STIM_TUSER_EN
      chk({p, "_user_b3"}, 32'(m_axis_tuser), 32'd3);
`endif
      tick();
      chk({p, "_tvalid_b4"}, 32'(m_axis_tvalid), 32'd1);
      chk({p, "_a_b4"}, m_axis_tdata_a, 32'h0000_0000);
      chk({p, "_b_b4"}, m_axis_tdata_b, 32'h8000_0000);
      chk({p, "_last_b4"}, 32'(m_axis_tlast), 32'd1);
      chk({p, "_done_pre"}, 32'(done), 32'd0);
`ifdef FLT_STIM_TUSER_EN
      chk({p, "_user_b4"}, 32'(m_axis_tuser), 32'd4);
`endif
      tick();
      chk({p, "_tvalid_end"}, 32'(m_axis_tvalid), 32'd0);
      chk({p, "_done_end"}, 32'(done), 32'd1);
   endtask

   initial begin
      rst           = 1'b1;
      in_valid      = 1'b0;
      in_addr       = 4'd0;
      m_axis_tready = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_a", m_axis_tdata_a, 32'h0);
      chk("rst_b", m_axis_tdata_b, 32'h0);
      chk("rst_last", 32'(m_axis_tlast), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      rst = 1'b0;

      // Scenario 1: streaming with tready=1
      run_s1("s1");

      // Scenario 3 (no reset, done stays sticky): six strobes into a stalled FIFO
      m_axis_tready = 1'b0;
      for (int i = 0; i < 6; i++) strobe(4'(i));
      in_valid = 1'b0;
      tick();
      chk("s3_ovf", 32'(overflow), 32'd1);
      chk("s3_drop", 32'(drop_cnt), 32'd2);
      chk("s3_count", 32'(dut.r_count), 32'd4);
      chk("s3_done_sticky", 32'(done), 32'd1);
      chk("s3_a0", m_axis_tdata_a, 32'h3F80_0000);
      chk("s3_b0", m_axis_tdata_b, 32'h4000_0000);
      m_axis_tready = 1'b1;
      tick();
      chk("s3_a1", m_axis_tdata_a, 32'h4040_0000);
      tick();
      chk("s3_a2", m_axis_tdata_a, 32'hBF80_0000);
      tick();
      chk("s3_a3", m_axis_tdata_a, 32'h7F80_0000);
      chk("s3_last3", 32'(m_axis_tlast), 32'd0);
      tick();
      chk("s3_tvalid_end", 32'(m_axis_tvalid), 32'd0);
      chk("s3_drop_end", 32'(drop_cnt), 32'd2);

      // Scenario 5: reset after two of four beats were handshaken
      strobe(4'd1);
      strobe(4'd2);
      strobe(4'd3);
      chk("s5_head_after1", m_axis_tdata_a, 32'hBF80_0000);
      strobe(4'd4);
      chk("s5_head_after2", m_axis_tdata_a, 32'h7F80_0000);
      rst      = 1'b1;
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      chk("s5_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("s5_count", 32'(dut.r_count), 32'd0);
      chk("s5_done", 32'(done), 32'd0);
      chk("s5_drop", 32'(drop_cnt), 32'd0);
      chk("s5_ovf", 32'(overflow), 32'd0);
      chk("s5_a", m_axis_tdata_a, 32'h0);
      tick();
      chk("s5_tvalid_post", 32'(m_axis_tvalid), 32'd0);
      run_s1("s5fresh");

      // Scenario 2: fill with tready=0, then drain back-to-back
      do_reset();
      m_axis_tready = 1'b0;
      for (int i = 1; i <= 4; i++) strobe(4'(i));
      in_valid = 1'b0;
      tick();
      chk("s2_count", 32'(dut.r_count), 32'd4);
      chk("s2_tvalid", 32'(m_axis_tvalid), 32'd1);
      chk("s2_head", m_axis_tdata_a, 32'h4040_0000);
      chk("s2_ovf", 32'(overflow), 32'd0);
      tick();
      chk("s2_head_stable", m_axis_tdata_a, 32'h4040_0000);
      chk("s2_tvalid_stable", 32'(m_axis_tvalid), 32'd1);
      m_axis_tready = 1'b1;
      tick();
      chk("s2_a2", m_axis_tdata_a, 32'hBF80_0000);
      tick();
      chk("s2_a3", m_axis_tdata_a, 32'h7F80_0000);
      tick();
      chk("s2_a4", m_axis_tdata_a, 32'h0000_0000);
      chk("s2_last4", 32'(m_axis_tlast), 32'd1);
      tick();
      chk("s2_tvalid_end", 32'(m_axis_tvalid), 32'd0);
      chk("s2_done", 32'(done), 32'd1);

      // Scenario 4: push into a full FIFO on a cycle that also pops
      do_reset();
      m_axis_tready = 1'b0;
      strobe(4'd0);
      strobe(4'd1);
      strobe(4'd2);
      strobe(4'd3);
      strobe(4'd2);
      in_valid = 1'b0;
      chk("s4_full", 32'(dut.r_count), 32'd4);
      chk("s4_head0", m_axis_tdata_a, 32'h3F80_0000);
      m_axis_tready = 1'b1;
      tick();
      chk("s4_count", 32'(dut.r_count), 32'd4);
      chk("s4_ovf", 32'(overflow), 32'd0);
      chk("s4_drop", 32'(drop_cnt), 32'd0);
      chk("s4_a1", m_axis_tdata_a, 32'h4040_0000);
      tick();
      chk("s4_a2", m_axis_tdata_a, 32'hBF80_0000);
      tick();
      chk("s4_a3", m_axis_tdata_a, 32'h7F80_0000);
      tick();
      chk("s4_a2wrap", m_axis_tdata_a, 32'hBF80_0000);
      chk("s4_b2wrap", m_axis_tdata_b, 32'h3F00_0000);
      tick();
      chk("s4_tvalid_end", 32'(m_axis_tvalid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
